rr_request_latch: RTL
=====================

// Module: rr_request_latch
// PURPOSE
// - Front-end of the round-robin arbiter: turns raw asynchronous interrupt lines into a
//   registered pending-request vector driving the arbiter's Priority_bus input.
// - Synchronises each line, detects rising edges and latches them as pending.
// - Clears a pending bit when the arbiter reports it as served (Next_priority + Data_Valid).
// - Optionally counts edges lost while a request was already pending.
// PARAMETERS
// - N_REQ       4  number of request lines (2..16); grant index width GW = $clog2(N_REQ)
// - SYNC_STAGES 2  synchroniser flops per line (>=2)
// - CNT_W       4  width of each per-line overflow counter
// PORTS
// - clk           in  1          single clock, rising edge
// - rst           in  1          asynchronous active-low reset (0 = reset)
// - irq_in        in  N_REQ      raw async interrupt lines
// - irq_mask      in  N_REQ      1 = line enabled; 0 = its edges are dropped
// - Next_priority in  GW         index served by the arbiter
// - Data_Valid    in  1          qualifies Next_priority; one service per cycle
// - Priority_bus  out N_REQ      registered pending vector to the arbiter
// - pend_any      out 1          |Priority_bus (combinational from the register)
// - ovf_clr       in  1          sync pulse: clears all overflow state
// - ovf_flag      out 1          sticky: any overflow since reset/ovf_clr
// - ovf_cnt       out N_REQ*CNT_W per-line overflow counts, line i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
// - Reset (rst=0, async assert, sync-free deassert on clk): sync chains, edge history,
//   Priority_bus, ovf_flag and ovf_cnt all 0; pend_any=0.
// - Sync: irq_in[i] goes through SYNC_STAGES flops -> s[i]; s_d[i] = s[i] delayed 1 clk.
// - rise[i] = s[i] & ~s_d[i] & irq_mask[i] (mask sampled in the rise cycle only;
//   masking does not clear an existing pending bit).
// - clr[i] = Data_Valid & (Next_priority == i); indices >= N_REQ are ignored.
// - Per-line update each clk:
//   - rise & ~pend         -> pend=1
//   - rise & pend & ~clr   -> pend stays 1, overflow event on line i
//   - rise & clr           -> pend stays 1 (new edge replaces served one), no overflow
//   - ~rise & clr          -> pend=0
//   - otherwise            -> hold
// - Latency: irq_in rise setting up before clk edge k -> Priority_bus[i]=1 after edge
//   k+SYNC_STAGES (3 edges total incl. edge k at default). Clear: Data_Valid sampled
//   at edge k -> bit 0 after edge k.
// - A level held high produces exactly one pending event; line must go low
//   for >=1 synchronised cycle before it can re-trigger.
// - Pulses shorter than one clk period may be lost (not guaranteed to be captured).
// - Multiple lines may set in the same cycle; all are latched independently.
// - Priority_bus driven only from flops (no combinational path from inputs).
// CONFIGURATION
// - Macro RR_IRQ_OVF_CNT_EN:
//   - defined: overflow event increments ovf_cnt[i] saturating at 2^CNT_W-1 and sets
//     ovf_flag; ovf_clr zeroes all counters and ovf_flag next edge; ovf_clr and an
//     overflow in the same cycle -> clear wins (count 0, flag 0).
//   - undefined: counter/flag logic not built; ovf_cnt and ovf_flag tied to 0;
//     ovf_clr ignored; pending behaviour identical.
// TESTING
// - Reset: rst=0 with irq_in=4'hF toggling -> all outputs 0; release, lines held high
//   -> Priority_bus=4'hF exactly 3 clk later (SYNC_STAGES=2).
// - Set/clear: pulse irq_in[2] 2 clk -> Priority_bus=4'b0100; Next_priority=2,
//   Data_Valid=1 one clk -> Priority_bus=4'b0000, pend_any=0.
// - Simultaneous: edge on line 1 arrives in same cycle as clear of line 1 -> bit 1
//   stays 1, ovf_cnt[1]=0.
// - Mask: irq_mask=4'b1110, edge on line 0 -> bit 0 never sets; pending bit 3 then
//   masked -> remains 1 until cleared.
// - Overflow (macro on): 17 edges on line 3 with no clear -> ovf_cnt[3]=4'hF saturated,
//   ovf_flag=1; ovf_clr pulse -> both 0, Priority_bus[3] still 1.
// - Macro off: same 17 edges -> ovf_cnt=0, ovf_flag=0, Priority_bus[3]=1.

Source files
------------

// File: rtl/rr_request_latch.sv
// ---------------------------------------------------------------------------
// rr_request_latch
// Front-end of the round-robin arbiter. Each raw interrupt line is synchronised,
// its rising edge detected (qualified by irq_mask) and latched as a pending bit.
// A pending bit is cleared when the arbiter reports that index as served.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-low reset
//   irq_in         raw asynchronous interrupt lines
//   irq_mask       1 = line enabled, 0 = its edges are dropped
//   Next_priority  index served by the arbiter
//   Data_Valid     qualifies Next_priority
//   Priority_bus   registered pending vector
//   pend_any       OR of Priority_bus
//   ovf_clr        synchronous pulse clearing all overflow state
//   ovf_flag       sticky: an overflow happened since reset/ovf_clr
//   ovf_cnt        per-line overflow counts, line i at [i*CNT_W +: CNT_W]
//
// Build option: define RR_IRQ_OVF_CNT_EN to build the overflow counters and
// flag. When it is undefined, ovf_cnt/ovf_flag are tied to 0 and ovf_clr is
// ignored; pending behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module rr_request_latch #(
    parameter int N_REQ       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           irq_in,
    input  logic [N_REQ-1:0]           irq_mask,
    input  logic [$clog2(N_REQ)-1:0]   Next_priority,
    input  logic                       Data_Valid,
    output logic [N_REQ-1:0]           Priority_bus,
    output logic                       pend_any,
    input  logic                       ovf_clr,
    output logic                       ovf_flag,
    output logic [N_REQ*CNT_W-1:0]     ovf_cnt
);

    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0] sync_q [SYNC_STAGES];
    logic [N_REQ-1:0] sync_d [SYNC_STAGES];
    logic [N_REQ-1:0] s_dly_q, s_dly_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] rise, clr, ovf_evt;

    always_comb begin
        sync_d[0] = irq_in;
        for (int j = 1; j < SYNC_STAGES; j++) begin
            sync_d[j] = sync_q[j-1];
        end
        s_dly_d = sync_q[SYNC_STAGES-1];
    end

    // A new edge arriving in the same cycle as the service replaces the served
    // request, so the bit stays set and no overflow is recorded.
    always_comb begin
        rise    = sync_q[SYNC_STAGES-1] & ~s_dly_q & irq_mask;
        clr     = '0;
        pend_d  = pend_q;
        ovf_evt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            clr[i] = Data_Valid && (Next_priority == GW'(i));
            if (rise[i]) begin
                pend_d[i]  = 1'b1;
                ovf_evt[i] = pend_q[i] & ~clr[i];
            end else if (clr[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            s_dly_q <= '0;
            pend_q  <= '0;
        end else begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_d[j];
            end
            s_dly_q <= s_dly_d;
            pend_q  <= pend_d;
        end
    end

    assign Priority_bus = pend_q;
    assign pend_any     = |pend_q;

`ifdef RR_IRQ_OVF_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];
    logic             flag_q, flag_d;

    // ovf_clr takes priority over an overflow in the same cycle.
    always_comb begin
        flag_d = flag_q;
        if (ovf_clr) begin
            flag_d = 1'b0;
        end else if (|ovf_evt) begin
            flag_d = 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ovf_clr) begin
                cnt_d[i] = '0;
            end else if (ovf_evt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            flag_q <= flag_d;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        ovf_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ovf_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign ovf_flag = flag_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr ^ (|ovf_evt);
    assign ovf_cnt    = '0;
    assign ovf_flag   = 1'b0;
`endif

endmodule
